// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: the transmitter state encoding, frame sizes and
// the keyboard command bytes.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        STOP,
        ACK,
        WAITIDLE,
        DONE,
        ERR
    } ps2_state_t;

    localparam int DATA_BITS   = 8;
    localparam int FRAME_EDGES = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock. Shared with the PS/2 receiver.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ps2Clk,
    input  logic ps2Data,
    output logic clk_sync,
    output logic data_sync,
    output logic fall_edge
);

    logic [1:0] pin_vec;
    logic [1:0] sync_vec;
    logic       clk_prev_reg;

    assign pin_vec = {ps2Data, ps2Clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Idle lines are pulled high, so reset to 1 to avoid a spurious edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_vec[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= sync_vec[0];
        end
    end

    assign clk_sync  = sync_vec[0];
    assign data_sync = sync_vec[1];
    assign fall_edge = clk_prev_reg & ~sync_vec[0];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues request-to-send,
// shifts out one byte with odd parity on device clock edges and checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       ps2ClkOe,
    output logic       ps2DataOe,
    input  logic       start,
    input  logic [7:0] txData,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    logic clk_sync;
    logic data_sync;
    logic fall_edge;

    ps2_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .fall_edge (fall_edge)
    );

    ps2_state_t       state_reg;
    logic [7:0]       shift_reg;
    logic             parity_reg;
    logic [3:0]       bit_idx_reg;
    logic [INH_W-1:0] inh_cnt_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             clk_oe_reg;
    logic             data_oe_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            bit_idx_reg <= '0;
            inh_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= txData;
                        parity_reg  <= odd_parity(txData);
                        busy_reg    <= 1'b1;
                        clk_oe_reg  <= 1'b1;
                        inh_cnt_reg <= '0;
                        state_reg   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    // Leave early by one so the clock is held exactly
                    // INHIBIT_CYCLES including the RTS cycle.
                    if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 2)) begin
                        data_oe_reg <= 1'b1;
                        state_reg   <= RTS;
                    end else begin
                        inh_cnt_reg <= inh_cnt_reg + 1'b1;
                    end
                end
                RTS: begin
                    clk_oe_reg  <= 1'b0;
                    to_cnt_reg  <= '0;
                    bit_idx_reg <= '0;
                    state_reg   <= SEND;
                end
                SEND, STOP, ACK, WAITIDLE: begin
                    if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        error_reg   <= 1'b1;
                        busy_reg    <= 1'b0;
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        state_reg   <= ERR;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                        if (state_reg == SEND && fall_edge) begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            if (bit_idx_reg == 4'(DATA_BITS)) begin
                                data_oe_reg <= ~parity_reg;
                                state_reg   <= STOP;
                            end else begin
                                data_oe_reg <= ~shift_reg[0];
                                shift_reg   <= shift_reg >> 1;
                            end
                        end else if (state_reg == STOP && fall_edge) begin
                            data_oe_reg <= 1'b0;
                            state_reg   <= ACK;
                        end else if (state_reg == ACK && fall_edge) begin
                            if (data_sync) begin
                                error_reg <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= ERR;
                            end else begin
                                state_reg <= WAITIDLE;
                            end
                        end else if (state_reg == WAITIDLE && clk_sync && data_sync) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                ERR: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ps2ClkOe  = clk_oe_reg;
    assign ps2DataOe = data_oe_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;

endmodule
